// File: rtl/riscv_pkg.sv
// +----------------------------------------------------------------------------+
// | riscv_pkg : shared constants and fetch state encoding for the IF stage     |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] RV_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/if_pc_reg.sv
// +----------------------------------------------------------------------------+
// | if_pc_reg : program counter with +4 advance and word-aligned redirect      |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_pc_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_branch,
    input  logic [XLEN-1:0] branch_target,
    input  logic            advance,
    output logic [XLEN-1:0] pc_q
);

    // Redirect has priority; low target bits are dropped to keep the PC word aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (load_branch) begin
            pc_q <= branch_target & ~32'h0000_0003;
        end else if (advance) begin
            pc_q <= pc_q + 32'd4;
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | if_fetch_unit : IF stage, one outstanding imem request, stall and redirect |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PC_write,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PC_Branch,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] PC_IF,
    output logic [XLEN-1:0] INSTRUCTION_IF,
    output logic            fetch_valid
);

    fetch_state_e    state_q;
    logic            drop_q;
    logic [XLEN-1:0] hold_q;
    logic [XLEN-1:0] pc_q;

    logic in_req;
    logic in_wait;
    logic in_hold;
    logic deliver_now;
    logic present_hold;
    logic advance;

    assign in_req  = (state_q == FS_REQ);
    assign in_wait = (state_q == FS_WAIT);
    assign in_hold = (state_q == FS_HOLD);

    // A response that survives redirects is either passed straight through or parked in hold_q.
    assign deliver_now  = in_wait & imem_rvalid & ~drop_q & ~PCSrc & PC_write;
    assign present_hold = in_hold & ~PCSrc;
    assign advance      = (deliver_now | present_hold) & PC_write;

    assign imem_req       = in_req & ~PCSrc;
    assign imem_addr      = pc_q;
    assign PC_IF          = pc_q;
    assign fetch_valid    = deliver_now | present_hold;
    assign INSTRUCTION_IF = deliver_now  ? imem_rdata :
                            present_hold ? hold_q     : NOP_INSTR;

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .load_branch   (PCSrc),
        .branch_target (PC_Branch),
        .advance       (advance),
        .pc_q          (pc_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FS_REQ;
            drop_q  <= 1'b0;
            hold_q  <= NOP_INSTR;
        end else begin
            case (state_q)
                FS_REQ: begin
                    if (imem_req && imem_ready) begin
                        state_q <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        drop_q <= 1'b0;
                        if (PCSrc || drop_q || PC_write) begin
                            state_q <= FS_REQ;
                        end else begin
                            hold_q  <= imem_rdata;
                            state_q <= FS_HOLD;
                        end
                    end else if (PCSrc) begin
                        // The in-flight response now belongs to a squashed path.
                        drop_q <= 1'b1;
                    end
                end
                FS_HOLD: begin
                    if (PCSrc || PC_write) begin
                        state_q <= FS_REQ;
                    end
                end
                default: begin
                    state_q <= FS_REQ;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | tb_if_fetch_unit : randomized scoreboard bench for if_fetch_unit           |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          CYCLES = 4000;

    logic        clk = 1'b0;
    logic        reset;
    logic        PC_write;
    logic        PCSrc;
    logic [31:0] PC_Branch;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PC_IF;
    logic [31:0] INSTRUCTION_IF;
    logic        fetch_valid;

    if_fetch_unit #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .PC_write       (PC_write),
        .PCSrc          (PCSrc),
        .PC_Branch      (PC_Branch),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .PC_IF          (PC_IF),
        .INSTRUCTION_IF (INSTRUCTION_IF),
        .fetch_valid    (fetch_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          delivered = 0;
    bit          run = 0;
    bit          outstanding = 0;
    bit          poison = 0;
    bit          fresh = 0;
    bit          directed = 1;
    bit          reset_done = 0;
    int          lat = 0;
    logic [31:0] mem_addr = '0;
    logic [31:0] arch_pc = RST_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFC;
            1:       return 32'h0000_0103;
            2:       return 32'h0000_0100;
            default: return $urandom;
        endcase
    endfunction

    // Stimulus side: drives the hazard/redirect inputs and the memory, and
    // records every response that must reach the decode stage.
    task automatic drive();
        fresh       = 0;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (directed) begin
            PC_write   = 1'b1;
            PCSrc      = 1'b0;
            imem_ready = 1'b1;
        end else begin
            PC_write   = ($urandom_range(0, 3) != 0);
            PCSrc      = ($urandom_range(0, 9) == 0);
            PC_Branch  = pick_target();
            imem_ready = ($urandom_range(0, 3) != 0);
        end
        if (outstanding) begin
            if (lat > 0) lat--;
            if (lat == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                if (!poison && !PCSrc) begin
                    exp_q.push_back('{pc: mem_addr, instr: imem_rdata});
                    fresh = 1;
                end
            end
        end else if (!directed && $urandom_range(0, 7) == 0) begin
            imem_rvalid = 1'b1;
        end
    endtask

    // Monitor side: compares outputs against the model and retires entries.
    always @(negedge clk) begin
        if (run) begin
            automatic bit exp_fv  = (exp_q.size() > 0) && !PCSrc && (PC_write || !fresh);
            automatic bit exp_req = !outstanding && (exp_q.size() == 0) && !PCSrc;
            chk("fetch_valid", 32'(fetch_valid), 32'(exp_fv));
            chk("pc_if", PC_IF, arch_pc);
            chk("imem_req", 32'(imem_req), 32'(exp_req));
            if (imem_req) chk("imem_addr", imem_addr, arch_pc);
            if (exp_fv) begin
                chk("instr", INSTRUCTION_IF, exp_q[0].instr);
                chk("instr_pc", PC_IF, exp_q[0].pc);
            end else begin
                chk("bubble", INSTRUCTION_IF, NOP);
            end

            if (outstanding && imem_rvalid) outstanding = 0;
            if (imem_req && imem_ready) begin
                outstanding = 1;
                poison      = 0;
                mem_addr    = arch_pc;
                lat         = directed ? 1 : $urandom_range(1, 3);
            end
            if (PCSrc) begin
                arch_pc = PC_Branch & ~32'h3;
                exp_q.delete();
                if (outstanding) poison = 1;
            end else if (exp_fv && PC_write) begin
                void'(exp_q.pop_front());
                arch_pc = arch_pc + 32'd4;
                delivered++;
            end
        end
    end

    initial begin
        reset       = 1'b1;
        PC_write    = 1'b0;
        PCSrc       = 1'b0;
        PC_Branch   = '0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_instr", INSTRUCTION_IF, NOP);
        chk("rst_pc_if", PC_IF, RST_PC);
        chk("rst_imem_req", 32'(imem_req), 32'd1);
        reset = 1'b0;
        drive();
        run = 1;

        for (int i = 0; i < CYCLES; i++) begin
            @(posedge clk);
            #1;
            if (i == 40) directed = 0;
            if (i >= 2000 && !reset_done && outstanding) begin
                // Asynchronous reset in the middle of a WAIT cycle.
                imem_rvalid = 1'b0;
                PCSrc       = 1'b0;
                run         = 0;
                #2;
                reset = 1'b1;
                #1;
                chk("async_fetch_valid", 32'(fetch_valid), 32'd0);
                chk("async_instr", INSTRUCTION_IF, NOP);
                chk("async_pc_if", PC_IF, RST_PC);
                chk("async_imem_req", 32'(imem_req), 32'd1);
                exp_q.delete();
                outstanding = 0;
                poison      = 0;
                lat         = 0;
                fresh       = 0;
                arch_pc     = RST_PC;
                reset_done  = 1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                drive();
                run = 1;
            end else begin
                drive();
            end
        end

        @(negedge clk);
        run = 0;
        chk("async_reset_exercised", 32'(reset_done), 32'd1);
        chk("progress", 32'(delivered > 200), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
